// File: rtl/cjump_rs.sv
// Reservation station for the conditional-jump FU: collapsing queue of cjump ops that
// snoops the CDB for missing operands and issues the oldest fully-ready op when the FU is idle.
module cjump_rs #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   input  logic                           dispatch_valid,
   output logic                           dispatch_ready,
   input  logic [7:0]                     d_operand,
   input  logic [1:0]                     d_src_rdy,
   input  logic [1:0][3:0]                d_src_tag,
   input  logic [1:0][7:0]                d_src_val,
   input  logic [7:0]                     d_wbs,
   input  logic [7:0]                     d_flags,
   input  logic [3:0]                     d_robid,
   input  logic                           cdb_valid,
   input  logic [3:0]                     cdb_id,
   input  logic [7:0]                     cdb_val,
   input  logic                           fu_busy,
   output logic                           issue_transmit,
   output logic [7:0]                     issue_operand,
   output logic [1:0][7:0]                issue_depvals,
   output logic [7:0]                     issue_wbs,
   output logic [7:0]                     issue_flags,
   output logic [3:0]                     issue_robid,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef struct packed {
      logic            valid;
      logic [7:0]      operand;
      logic [1:0]      rdy;
      logic [1:0][3:0] tag;
      logic [1:0][7:0] val;
      logic [7:0]      wbs;
      logic [7:0]      flags;
      logic [3:0]      robid;
   } ent_t;

   ent_t            ent_q [DEPTH];
   ent_t            ent_d [DEPTH];
   ent_t            snp   [DEPTH+1];
   ent_t            new_ent;
   ent_t            sel_ent;
   logic [CW-1:0]   count_q, count_d, widx;
   logic [IW-1:0]   sel;
   logic [DEPTH-1:0] elig;
   logic            fire_c, accept_c;
   logic            transmit_q;
   logic [7:0]      operand_q, wbs_q, flags_q;
   logic [1:0][7:0] depvals_q;
   logic [3:0]      robid_q;

   assign dispatch_ready = (count_q < CW'(DEPTH));

   // Issue select on registered state: lowest index wins.
   always_comb begin
      elig    = '0;
      sel     = '0;
      sel_ent = '0;
      for (int i = 0; i < DEPTH; i++) begin
         elig[i] = ent_q[i].valid & (&ent_q[i].rdy);
      end
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (elig[i]) begin
            sel     = IW'(i);
            sel_ent = ent_q[i];
         end
      end
      fire_c   = (|elig) && !fu_busy && !transmit_q && !flush;
      accept_c = dispatch_valid && dispatch_ready && !flush;
   end

   // Snoop, collapse on issue, then append the dispatched op behind the survivors.
   always_comb begin
      snp[DEPTH] = '0;
      for (int i = 0; i < DEPTH; i++) begin
         snp[i] = ent_q[i];
         for (int s = 0; s < 2; s++) begin
            if (snp[i].valid && !snp[i].rdy[s] && cdb_valid && (snp[i].tag[s] == cdb_id)) begin
               snp[i].rdy[s] = 1'b1;
               snp[i].val[s] = cdb_val;
            end
         end
      end

      new_ent         = '0;
      new_ent.valid   = 1'b1;
      new_ent.operand = d_operand;
      new_ent.rdy     = d_src_rdy;
      new_ent.tag     = d_src_tag;
      new_ent.val     = d_src_val;
      new_ent.wbs     = d_wbs;
      new_ent.flags   = d_flags;
      new_ent.robid   = d_robid;
      for (int s = 0; s < 2; s++) begin
         if (!d_src_rdy[s] && cdb_valid && (d_src_tag[s] == cdb_id)) begin
            new_ent.rdy[s] = 1'b1;
            new_ent.val[s] = cdb_val;
         end
      end

      widx = count_q - CW'(fire_c);
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i] = (fire_c && (IW'(i) >= sel)) ? snp[i+1] : snp[i];
         if (accept_c && (CW'(i) == widx)) ent_d[i] = new_ent;
         if (flush) ent_d[i] = '0;
      end

      count_d = flush ? '0 : (count_q + CW'(accept_c) - CW'(fire_c));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent_q      <= '{default: '0};
         count_q    <= '0;
         transmit_q <= 1'b0;
         operand_q  <= '0;
         depvals_q  <= '0;
         wbs_q      <= '0;
         flags_q    <= '0;
         robid_q    <= '0;
      end else begin
         ent_q      <= ent_d;
         count_q    <= count_d;
         transmit_q <= fire_c;
         if (fire_c) begin
            operand_q <= sel_ent.operand;
            depvals_q <= sel_ent.val;
            wbs_q     <= sel_ent.wbs;
            flags_q   <= sel_ent.flags;
            robid_q   <= sel_ent.robid;
         end
      end
   end

   assign issue_transmit = transmit_q;
   assign issue_operand  = operand_q;
   assign issue_depvals  = depvals_q;
   assign issue_wbs      = wbs_q;
   assign issue_flags    = flags_q;
   assign issue_robid    = robid_q;
   assign count          = count_q;

endmodule
